// File: rtl/temporal_pkg.sv
// Shared types and sizes for the temporal (race-logic) edge encoder.
// Optional build macro: TEMPORAL_NO_SPIKE_EN (see temporal_lane).
package temporal_pkg;

    localparam int N_LANES = 8;
    localparam int VAL_W   = 3;
    localparam int T_MAX   = 2**VAL_W - 1;

    typedef enum logic [1:0] {
        ENC_IDLE = 2'd0,
        ENC_FIRE = 2'd1,
        ENC_GAP  = 2'd2
    } enc_state_t;

    typedef logic [VAL_W-1:0] tval_t;

endpackage

// File: rtl/temporal_edge_encoder_lane.sv
// One temporal lane: stored value plus registered step output (val <= k).
// TEMPORAL_NO_SPIKE_EN: the all-ones value never rises ("no spike").
module temporal_lane
    import temporal_pkg::*;
#(
    parameter int W = VAL_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] din,
    input  logic [W-1:0] kn,
    output logic         out
);

    localparam logic [W-1:0] VMAX = '1;

    logic [W-1:0] val;
    logic [W-1:0] v;
    logic         hit;

    // On accept the fresh value drives the k=0 compare directly.
    assign v = load ? din : val;

`ifdef TEMPORAL_NO_SPIKE_EN
    assign hit = (v <= kn) && (v != VMAX);
`else
    assign hit = (v <= kn);
`endif

    // Hold the lane value for the whole window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val <= '0;
        end else if (load) begin
            val <= din;
        end
    end

    // Registered step output; forced low outside FIRE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out <= 1'b0;
        end else begin
            out <= en & hit;
        end
    end

endmodule

// File: rtl/temporal_edge_encoder.sv
// Temporal edge encoder: replays N W-bit values as step edges over 2**W cycles.
// Optional build macro: TEMPORAL_NO_SPIKE_EN (all-ones value means no spike).
module temporal_edge_encoder
    import temporal_pkg::*;
#(
    parameter int N   = N_LANES,
    parameter int W   = VAL_W,
    parameter int GAP = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] in_vals,
    output logic [N-1:0]   out,
    output logic           window_start,
    output logic           window_done,
    output logic           busy
);

    localparam logic [W-1:0] KLAST = '1;
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [GW-1:0] GINIT = (GAP > 0) ? GW'(GAP - 1) : '0;

    enc_state_t    state;
    enc_state_t    state_n;
    logic [W-1:0]  k;
    logic [W-1:0]  k_n;
    logic [GW-1:0] g;
    logic [GW-1:0] g_n;
    logic          load;
    logic          fire_n;

    assign in_ready = (state == ENC_IDLE) & ~rst;
    assign busy     = (state != ENC_IDLE);

    // State, window counter and gap counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ENC_IDLE;
            k     <= '0;
            g     <= '0;
        end else begin
            state <= state_n;
            k     <= k_n;
            g     <= g_n;
        end
    end

    // Next state; fire_n/k_n describe the cycle being registered into.
    always_comb begin
        state_n = state;
        k_n     = k;
        g_n     = g;
        load    = 1'b0;
        fire_n  = 1'b0;
        unique case (state)
            ENC_IDLE: begin
                if (in_valid) begin
                    load    = 1'b1;
                    fire_n  = 1'b1;
                    k_n     = '0;
                    state_n = ENC_FIRE;
                end
            end
            ENC_FIRE: begin
                if (k == KLAST) begin
                    k_n = '0;
                    if (GAP > 0) begin
                        g_n     = GINIT;
                        state_n = ENC_GAP;
                    end else begin
                        state_n = ENC_IDLE;
                    end
                end else begin
                    k_n    = k + 1'b1;
                    fire_n = 1'b1;
                end
            end
            ENC_GAP: begin
                if (g == '0) begin
                    state_n = ENC_IDLE;
                end else begin
                    g_n = g - 1'b1;
                end
            end
            default: begin
                state_n = ENC_IDLE;
            end
        endcase
    end

    // Window marker pulses, aligned with the registered lane outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            window_start <= 1'b0;
            window_done  <= 1'b0;
        end else begin
            window_start <= load;
            window_done  <= fire_n && (k_n == KLAST);
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        temporal_lane #(
            .W (W)
        ) u_lane (
            .clk  (clk),
            .rst  (rst),
            .load (load),
            .en   (fire_n),
            .din  (in_vals[i*W +: W]),
            .kn   (k_n),
            .out  (out[i])
        );
    end

endmodule
